// File: rtl/mem_access_ctrl_pkg.sv
// Shared LC-3b types for the memory-stage controller.
// Word type, memory-op and controller-state enums, op helpers.
package mem_access_ctrl_pkg;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [2:0] {
        MOP_LDW = 3'd0,
        MOP_LDB = 3'd1,
        MOP_STW = 3'd2,
        MOP_STB = 3'd3,
        MOP_LDI = 3'd4,
        MOP_STI = 3'd5
    } lc3b_memop;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IND  = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } lc3b_mem_state;

    function automatic logic op_is_load(input lc3b_memop op);
        return (op == MOP_LDW) || (op == MOP_LDB) || (op == MOP_LDI);
    endfunction

    function automatic logic op_is_byte(input lc3b_memop op);
        return (op == MOP_LDB) || (op == MOP_STB);
    endfunction

    function automatic logic op_is_ind(input lc3b_memop op);
        return (op == MOP_LDI) || (op == MOP_STI);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_byte_lane.sv
// Byte-lane steering for LC-3b loads and stores.
// Pure combinational: byte enables, store placement, load alignment.
module mem_access_ctrl_byte_lane
    import mem_access_ctrl_pkg::*;
(
    input  lc3b_memop   i_op,
    input  logic        i_addr0,
    input  logic [15:0] i_wdata,
    input  logic [15:0] i_mdr,
    output logic [1:0]  o_be,
    output logic [15:0] o_wdata,
    output logic [15:0] o_ldata
);

    logic [7:0] w_byte;

    assign w_byte = i_addr0 ? i_mdr[15:8] : i_mdr[7:0];

    // Select lanes, replicate store bytes, zero-extend loaded bytes
    always_comb begin
        o_be    = 2'b11;
        o_wdata = i_wdata;
        o_ldata = 16'h0000;
        unique case (i_op)
            MOP_LDW, MOP_LDI: begin
                o_ldata = i_mdr;
            end
            MOP_LDB: begin
                o_be    = i_addr0 ? 2'b10 : 2'b01;
                o_wdata = 16'h0000;
                o_ldata = {8'h00, w_byte};
            end
            MOP_STB: begin
                o_be    = i_addr0 ? 2'b10 : 2'b01;
                o_wdata = {i_wdata[7:0], i_wdata[7:0]};
            end
            MOP_STW, MOP_STI: begin
                o_ldata = 16'h0000;
            end
            default: begin
                o_be = 2'b00;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// LC-3b memory-stage controller: one load/store at a time,
// indirect pointer chase, memory handshake, aligned load result.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  lc3b_memop   req_op,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [15:0] load_data,
    output logic [15:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_byte_enable,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_resp
);

    lc3b_mem_state r_state;
    lc3b_mem_state w_next;
    lc3b_memop     r_op;
    lc3b_word      r_addr;
    lc3b_word      r_wdata;
    lc3b_word      r_mdr;

    logic [1:0]  w_be;
    logic [15:0] w_wdata;
    logic [15:0] w_ldata;
    logic [15:0] w_word_addr;

    assign w_word_addr = {r_addr[15:1], 1'b0};

    mem_access_ctrl_byte_lane u_lane (
        .i_op    (r_op),
        .i_addr0 (r_addr[0]),
        .i_wdata (r_wdata),
        .i_mdr   (r_mdr),
        .o_be    (w_be),
        .o_wdata (w_wdata),
        .o_ldata (w_ldata)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: accept, chase pointer, access, one-cycle done
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_next = op_is_ind(req_op) ? ST_IND : ST_ACC;
                end
            end
            ST_IND: begin
                if (mem_resp) begin
                    w_next = ST_ACC;
                end
            end
            ST_ACC: begin
                if (mem_resp) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Request latch, pointer replacement and load capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op    <= MOP_LDW;
            r_addr  <= 16'h0000;
            r_wdata <= 16'h0000;
            r_mdr   <= 16'h0000;
        end else begin
            if (r_state == ST_IDLE && req_valid) begin
                r_op    <= req_op;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (r_state == ST_IND && mem_resp) begin
                r_addr <= mem_rdata;
            end
            if (r_state == ST_ACC && mem_resp && op_is_load(r_op)) begin
                r_mdr <= mem_rdata;
            end
        end
    end

    // Output decode from registered state only
    always_comb begin
        done            = 1'b0;
        load_data       = 16'h0000;
        mem_address     = 16'h0000;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 2'b00;
        mem_wdata       = 16'h0000;
        unique case (r_state)
            ST_IDLE: begin
                done = 1'b0;
            end
            ST_IND: begin
                mem_read        = 1'b1;
                mem_address     = w_word_addr;
                mem_byte_enable = 2'b11;
            end
            ST_ACC: begin
                mem_read        = op_is_load(r_op);
                mem_write       = ~op_is_load(r_op);
                mem_address     = w_word_addr;
                mem_byte_enable = w_be;
                mem_wdata       = w_wdata;
            end
            ST_DONE: begin
                done      = 1'b1;
                load_data = w_ldata;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

    assign stall = req_valid & ~done;

endmodule
